// File: rtl/sound_cmd_latch_if.sv
// 68k/Z80 sound-code bus between the host side (master) and sound_cmd_latch (slave).
interface sound_cmd_if;
  logic       SNDDT;
  logic [7:0] DIN;
  logic       SNDON;
  logic       nSNDCS;
  logic       nRD;
  logic       nM1;
  logic       nIORQ;
  logic [7:0] DOUT;
  logic       DOUT_OE;
  logic       nINT;
  logic       EMPTY;
  logic       FULL;
  logic       OVF;

  modport master (
    output SNDDT, DIN, SNDON, nSNDCS, nRD, nM1, nIORQ,
    input  DOUT, DOUT_OE, nINT, EMPTY, FULL, OVF
  );

  modport slave (
    input  SNDDT, DIN, SNDON, nSNDCS, nRD, nM1, nIORQ,
    output DOUT, DOUT_OE, nINT, EMPTY, FULL, OVF
  );
endinterface

// File: rtl/sound_cmd_latch.sv
// 68k->Z80 sound command latch with Z80 IRQ handshake.
// Define SNDCMD_FIFO_EN to replace the single latch with a 2^DEPTH_LOG2-entry FIFO.
module sound_cmd_latch #(
  parameter int unsigned DEPTH_LOG2 = 2
) (
  input  logic        clk_main,
  input  logic        nRESET,
  sound_cmd_if.slave  bus
);

  if (DEPTH_LOG2 < 1 || DEPTH_LOG2 > 8) begin : g_depth_chk
    $error("sound_cmd_latch: DEPTH_LOG2 must be in 1..8");
  end

  logic rd_term, ack_term, rd_active;
  logic snddt_q, snddt_d, sndon_q, sndon_d, ack_q, ack_d;
  logic irq_q, irq_d;
  logic wr_ev, sndon_rise, ack_fall;
  logic [7:0] head;

  assign rd_term    = bus.nSNDCS | bus.nRD;
  assign ack_term   = bus.nM1 | bus.nIORQ;
  assign wr_ev      = snddt_q & ~bus.SNDDT;
  assign sndon_rise = ~sndon_q & bus.SNDON;
  assign ack_fall   = ack_q & ~ack_term;
  // Gated by reset so the bus is released the instant reset asserts.
  assign rd_active  = ~rd_term & nRESET;

  always_comb begin
    snddt_d = bus.SNDDT;
    sndon_d = bus.SNDON;
    ack_d   = ack_term;
    irq_d   = irq_q;
    if (ack_fall)   irq_d = 1'b0;
    if (sndon_rise) irq_d = 1'b1;
  end

  always_ff @(posedge clk_main or negedge nRESET) begin
    if (!nRESET) begin
      snddt_q <= 1'b1;
      sndon_q <= 1'b0;
      ack_q   <= 1'b1;
      irq_q   <= 1'b0;
    end else begin
      snddt_q <= snddt_d;
      sndon_q <= sndon_d;
      ack_q   <= ack_d;
      irq_q   <= irq_d;
    end
  end

`ifdef SNDCMD_FIFO_EN
  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] CNT_FULL = {1'b1, {DEPTH_LOG2{1'b0}}};

  logic [7:0]            mem_q [DEPTH];
  logic [7:0]            mem_d [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   cnt_q, cnt_d;
  logic [7:0]            last_q, last_d;
  logic                  ovf_q, ovf_d, rd_q, rd_d;
  logic                  fifo_empty, fifo_full, push, pop;

  assign fifo_empty = (cnt_q == '0);
  assign fifo_full  = (cnt_q == CNT_FULL);
  assign push       = wr_ev & ~fifo_full;
  assign pop        = ~rd_q & rd_term & ~fifo_empty;
  // An empty FIFO keeps presenting whatever was popped last.
  assign head       = fifo_empty ? last_q : mem_q[rd_ptr_q];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    last_d   = last_q;
    ovf_d    = ovf_q;
    rd_d     = rd_term;
    if (push) begin
      mem_d[wr_ptr_q] = bus.DIN;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (wr_ev && fifo_full) ovf_d = 1'b1;
    if (pop) begin
      last_d   = mem_q[rd_ptr_q];
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    if (push && !pop)      cnt_d = cnt_q + 1'b1;
    else if (pop && !push) cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk_main or negedge nRESET) begin
    if (!nRESET) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      last_q   <= '0;
      ovf_q    <= 1'b0;
      rd_q     <= 1'b1;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      last_q   <= last_d;
      ovf_q    <= ovf_d;
      rd_q     <= rd_d;
    end
  end

  assign bus.EMPTY = fifo_empty;
  assign bus.FULL  = fifo_full;
  assign bus.OVF   = ovf_q;
`else
  // Reads never consume the latch, so the end-of-read edge has no use here.
  logic [7:0] latch_q, latch_d;
  logic       empty_q, empty_d;

  assign head = latch_q;

  always_comb begin
    latch_d = latch_q;
    empty_d = empty_q;
    if (wr_ev) begin
      latch_d = bus.DIN;
      empty_d = 1'b0;
    end
  end

  always_ff @(posedge clk_main or negedge nRESET) begin
    if (!nRESET) begin
      latch_q <= '0;
      empty_q <= 1'b1;
    end else begin
      latch_q <= latch_d;
      empty_q <= empty_d;
    end
  end

  assign bus.EMPTY = empty_q;
  assign bus.FULL  = 1'b0;
  assign bus.OVF   = 1'b0;
`endif

  assign bus.DOUT    = rd_active ? head : 8'h00;
  assign bus.DOUT_OE = rd_active;
  assign bus.nINT    = ~irq_q;

endmodule

// File: tb/tb_sound_cmd_latch.sv
// Directed self-checking bench for sound_cmd_latch (latch build by default, FIFO build with SNDCMD_FIFO_EN).
module tb_sound_cmd_latch;

  logic clk = 1'b0;
  logic nRESET = 1'b0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  sound_cmd_if bus ();

  sound_cmd_latch #(.DEPTH_LOG2(2)) dut (
    .clk_main (clk),
    .nRESET   (nRESET),
    .bus      (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [7:0] d);
    bus.DIN   = d;
    bus.SNDDT = 1'b0;
    tick();
    bus.SNDDT = 1'b1;
    tick();
  endtask

  task automatic rd_begin();
    bus.nSNDCS = 1'b0;
    bus.nRD    = 1'b0;
    #1;
  endtask

  task automatic rd_end();
    bus.nSNDCS = 1'b1;
    bus.nRD    = 1'b1;
    tick();
  endtask

  initial begin
    bus.SNDDT  = 1'b1;
    bus.DIN    = 8'h00;
    bus.SNDON  = 1'b0;
    bus.nSNDCS = 1'b1;
    bus.nRD    = 1'b1;
    bus.nM1    = 1'b1;
    bus.nIORQ  = 1'b1;

    // Reset state
    tick();
    tick();
    chk("rst_nint",  {7'd0, bus.nINT},    8'h01);
    chk("rst_dout",  bus.DOUT,            8'h00);
    chk("rst_oe",    {7'd0, bus.DOUT_OE}, 8'h00);
    chk("rst_empty", {7'd0, bus.EMPTY},   8'h01);
    chk("rst_full",  {7'd0, bus.FULL},    8'h00);
    chk("rst_ovf",   {7'd0, bus.OVF},     8'h00);
    nRESET = 1'b1;
    tick();
    chk("post_rst_nint",  {7'd0, bus.nINT},  8'h01);
    chk("post_rst_empty", {7'd0, bus.EMPTY}, 8'h01);

    // Single write, 1-cycle latency
    bus.DIN   = 8'h5A;
    bus.SNDDT = 1'b0;
    tick();
    bus.SNDDT = 1'b1;
    chk("wr1_empty",   {7'd0, bus.EMPTY},   8'h00);
    chk("wr1_dout_idle", bus.DOUT,          8'h00);
    rd_begin();
    chk("wr1_dout",    bus.DOUT,            8'h5A);
    chk("wr1_oe",      {7'd0, bus.DOUT_OE}, 8'h01);
    tick();
    chk("wr1_dout_held", bus.DOUT,          8'h5A);
    rd_end();
    chk("wr1_oe_off",  {7'd0, bus.DOUT_OE}, 8'h00);
`ifdef SNDCMD_FIFO_EN
    chk("wr1_after_pop_empty", {7'd0, bus.EMPTY}, 8'h01);
`else
    chk("wr1_after_rd_empty",  {7'd0, bus.EMPTY}, 8'h00);
    rd_begin();
    chk("wr1_reread", bus.DOUT, 8'h5A);
    rd_end();
`endif

    // Held-low SNDDT writes once, with the value present at the falling edge
    bus.DIN   = 8'h11;
    bus.SNDDT = 1'b0;
    tick();
    bus.DIN   = 8'h22;
    tick();
    tick();
    bus.SNDDT = 1'b1;
    tick();
    rd_begin();
    chk("held_wr_dout", bus.DOUT, 8'h11);
    tick();
    rd_end();

    // IRQ handshake
    bus.SNDON = 1'b1;
    tick();
    chk("irq_set",  {7'd0, bus.nINT}, 8'h00);
    tick();
    chk("irq_hold", {7'd0, bus.nINT}, 8'h00);
    bus.nM1   = 1'b0;
    bus.nIORQ = 1'b0;
    tick();
    chk("ack_c1", {7'd0, bus.nINT}, 8'h01);
    tick();
    chk("ack_c2", {7'd0, bus.nINT}, 8'h01);
    tick();
    chk("ack_c3", {7'd0, bus.nINT}, 8'h01);
    bus.nM1   = 1'b1;
    bus.nIORQ = 1'b1;
    bus.SNDON = 1'b0;
    tick();
    chk("irq_idle", {7'd0, bus.nINT}, 8'h01);

    // Race: SNDON rise and ack fall in the same cycle, set wins
    bus.SNDON = 1'b1;
    bus.nM1   = 1'b0;
    bus.nIORQ = 1'b0;
    tick();
    chk("race_set_wins", {7'd0, bus.nINT}, 8'h00);
    tick();
    chk("race_held_ack", {7'd0, bus.nINT}, 8'h00);
    bus.nM1   = 1'b1;
    bus.nIORQ = 1'b1;
    tick();
    bus.nM1   = 1'b0;
    bus.nIORQ = 1'b0;
    tick();
    chk("race_later_ack", {7'd0, bus.nINT}, 8'h01);
    bus.nM1   = 1'b1;
    bus.nIORQ = 1'b1;
    bus.SNDON = 1'b0;
    tick();

`ifdef SNDCMD_FIFO_EN
    // FIFO order and overflow
    wr(8'h01);
    wr(8'h02);
    wr(8'h03);
    chk("fifo_not_full3", {7'd0, bus.FULL}, 8'h00);
    wr(8'h04);
    chk("fifo_full4",  {7'd0, bus.FULL}, 8'h01);
    chk("fifo_ovf4",   {7'd0, bus.OVF},  8'h00);
    wr(8'h05);
    chk("fifo_ovf5",   {7'd0, bus.OVF},  8'h01);
    for (int i = 1; i <= 4; i++) begin
      rd_begin();
      tick();
      chk("fifo_rd", bus.DOUT, 8'(i));
      rd_end();
    end
    chk("fifo_empty", {7'd0, bus.EMPTY}, 8'h01);
    chk("fifo_ovf_sticky", {7'd0, bus.OVF}, 8'h01);
    rd_begin();
    chk("fifo_empty_rd", bus.DOUT, 8'h04);
    rd_end();
    // Simultaneous write and pop: counter unchanged
    wr(8'h66);
    wr(8'h77);
    rd_begin();
    tick();
    bus.nSNDCS = 1'b1;
    bus.nRD    = 1'b1;
    bus.DIN    = 8'h88;
    bus.SNDDT  = 1'b0;
    tick();
    bus.SNDDT  = 1'b1;
    rd_begin();
    chk("fifo_wr_pop_head", bus.DOUT, 8'h77);
    tick();
    rd_end();
    rd_begin();
    tick();
    chk("fifo_wr_pop_tail", bus.DOUT, 8'h88);
    rd_end();
    chk("fifo_wr_pop_empty", {7'd0, bus.EMPTY}, 8'h01);
`else
    // Latch overwrite
    wr(8'hA0);
    wr(8'hA1);
    rd_begin();
    chk("ovw_dout", bus.DOUT, 8'hA1);
    chk("ovw_ovf",  {7'd0, bus.OVF},  8'h00);
    chk("ovw_full", {7'd0, bus.FULL}, 8'h00);
    rd_end();
`endif

    // Reset during an active read with IRQ pending
    wr(8'h3C);
    bus.SNDON = 1'b1;
    tick();
    rd_begin();
    tick();
    chk("pre_rst_nint", {7'd0, bus.nINT}, 8'h00);
    chk("pre_rst_dout", bus.DOUT,         8'h3C);
    nRESET = 1'b0;
    #1;
    chk("mid_rst_nint",  {7'd0, bus.nINT},    8'h01);
    chk("mid_rst_dout",  bus.DOUT,            8'h00);
    chk("mid_rst_oe",    {7'd0, bus.DOUT_OE}, 8'h00);
    chk("mid_rst_empty", {7'd0, bus.EMPTY},   8'h01);
    chk("mid_rst_ovf",   {7'd0, bus.OVF},     8'h00);
    tick();
    bus.SNDON  = 1'b0;
    bus.nSNDCS = 1'b1;
    bus.nRD    = 1'b1;
    #1;
    nRESET = 1'b1;
    tick();
    tick();
    chk("rel_nint",  {7'd0, bus.nINT},  8'h01);
    chk("rel_empty", {7'd0, bus.EMPTY}, 8'h01);
    rd_begin();
    chk("rel_dout",  bus.DOUT, 8'h00);
    rd_end();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sound_cmd_latch.md
SOUND_CMD_LATCH -- requirements
Module: sound_cmd_latch

Interface
REQ-001 SHALL have parameter DEPTH_LOG2, default 2: FIFO depth is 2^DEPTH_LOG2 entries; used only when SNDCMD_FIFO_EN is defined.
REQ-002 SHALL have port clk_main  in  1  single system clock; all logic on its rising edge.
REQ-003 SHALL have port nRESET  in  1  asynchronous, active-low reset.
REQ-004 SHALL have port SNDDT  in  1  active-low 68k sound-code write strobe, synchronous to clk_main.
REQ-005 SHALL have port DIN  in  8  68k data byte for the write (m68k_dout[7:0]).
REQ-006 SHALL have port SNDON  in  1  68k IRQ trigger level (IOWR bit 3); a rising edge requests a Z80 interrupt.
REQ-007 SHALL have port nSNDCS  in  1  Z80 active-low sound-code read select.
REQ-008 SHALL have port nRD  in  1  Z80 active-low read strobe.
REQ-009 SHALL have ports nM1 and nIORQ  in  1 each  Z80 active-low bus signals, used for interrupt acknowledge.
REQ-010 SHALL have port DOUT  out  8  sound code returned to the Z80.
REQ-011 SHALL have port DOUT_OE  out  1  high while the Z80 read is active.
REQ-012 SHALL have port nINT  out  1  active-low Z80 interrupt request.
REQ-013 SHALL have ports EMPTY, FULL and OVF  out  1 each  buffer status.

Function
REQ-014 SHALL register SNDDT, SNDON, the read term (nSNDCS|nRD) and the ack term (nM1|nIORQ) once, and SHALL detect edges by comparing each registered value with its live input.
REQ-015 SHALL treat a cycle with registered SNDDT=1 and live SNDDT=0 as a write event, and SHALL capture DIN on that cycle; a held-low SNDDT SHALL produce exactly one write.
REQ-016 SHALL set irq_pending on a SNDON rising edge (registered 0, live 1); nINT SHALL equal ~irq_pending.
REQ-017 SHALL clear irq_pending on an ack falling edge (registered 1, live 0); a held ack SHALL clear it only once.
REQ-018 SHALL keep irq_pending set when a SNDON rise and an ack edge occur in the same cycle (set wins).
REQ-019 SHALL drive DOUT_OE=1 combinationally while nSNDCS=0 and nRD=0, and DOUT SHALL then present the head value; otherwise DOUT SHALL be 8'h00 and DOUT_OE=0.
REQ-020 SHALL make a written byte visible on DOUT on the cycle after the write event (1-cycle latency).
REQ-021 SHALL keep the read path non-destructive during the read; any pop SHALL occur on the read term's rising edge (end of read).

Reset
REQ-022 SHALL on nRESET=0 immediately force: storage and head to 8'h00, irq_pending=0 (nINT=1), EMPTY=1, FULL=0, OVF=0, all edge registers=1, and SNDON register=0.
REQ-023 SHALL discard any write, read or acknowledge in progress when reset asserts mid-operation; no edge SHALL be detected on the first cycle after release for inputs already at their idle level.

Configuration
REQ-024 SHALL, when macro SNDCMD_FIFO_EN is defined, implement a 2^DEPTH_LOG2-entry FIFO with wrapping read and write pointers plus an occupancy counter of width DEPTH_LOG2+1.
REQ-025 SHALL, with SNDCMD_FIFO_EN defined, pop the FIFO at end-of-read when it is not empty; EMPTY and FULL SHALL derive from the counter.
REQ-026 SHALL, with SNDCMD_FIFO_EN defined, drop a write when FULL=1 and set sticky OVF, which is cleared only by reset.
REQ-027 SHALL, with SNDCMD_FIFO_EN defined, return the last popped value on an empty read, and SHALL handle a simultaneous write and pop with the counter unchanged and both performed.
REQ-028 SHALL, without SNDCMD_FIFO_EN, use a single 8-bit latch that each write overwrites; reads SHALL never pop.
REQ-029 SHALL, without SNDCMD_FIFO_EN, tie FULL and OVF to 0; EMPTY SHALL be 1 from reset until the first write and 0 afterwards.

Verification
REQ-030 SHALL cover a single write: pulse SNDDT low with DIN=8'h5A, then read -> DOUT=8'h5A with DOUT_OE=1 from the cycle after the write, EMPTY=0.
REQ-031 SHALL cover IRQ handshake: SNDON 0->1 -> nINT=0 the next cycle; nM1=nIORQ=0 for 3 cycles -> nINT=1 after the first cycle and stays 1.
REQ-032 SHALL cover the race: SNDON rise and ack edge in the same cycle -> nINT remains 0.
REQ-033 SHALL cover FIFO order and overflow (FIFO_EN, DEPTH_LOG2=2): write 8'h01..8'h05 -> FULL=1 after the 4th write, OVF=1 after the 5th; four reads return 8'h01,8'h02,8'h03,8'h04, then EMPTY=1.
REQ-034 SHALL cover latch overwrite (no FIFO_EN): write 8'hA0 then 8'hA1 with no read -> DOUT=8'hA1, OVF=0.
REQ-035 SHALL cover reset mid-operation: assert nRESET=0 during an active read with pending IRQ -> nINT=1, DOUT=8'h00, DOUT_OE=0, EMPTY=1 immediately.
